// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared branch-predict resolve/hint types and BTB sizing constants
package branch_target_buffer_pkg;

    localparam int unsigned BTB_ENTRIES             = 8;
    localparam int unsigned BITS_SATURATION_COUNTER = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        logic        is_lower_16;
        logic        valid;
        logic        clear;
    } branchpredict_t;

    typedef struct packed {
        logic [63:0] predict_address;
        logic        predict_taken;
        logic        is_lower_16;
        logic        valid;
    } branchpredict_sbe_t;

endpackage

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped PC-tagged BTB with 2-bit taken counters
// Combinational lookup for the fetch PC; one registered update port from EX.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = BTB_ENTRIES,
    parameter int unsigned CNT_BITS   = BITS_SATURATION_COUNTER
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [63:0]        vpc_i,
    input  branchpredict_t     branch_predict_i,
    output branchpredict_sbe_t branch_predict_o
);

    localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES);
    localparam int unsigned TAG_BITS   = 64 - INDEX_BITS - 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [63:0]         target;
        logic                is_lower_16;
        logic [CNT_BITS-1:0] cnt;
    } btb_entry_t;

    btb_entry_t r_btb [NR_ENTRIES];

    logic [INDEX_BITS-1:0] w_lu_idx;
    logic [TAG_BITS-1:0]   w_lu_tag;
    btb_entry_t            w_lu_entry;
    logic                  w_lu_hit;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    btb_entry_t            w_upd_entry;
    logic                  w_upd_hit;
    logic                  w_unused;

    function automatic logic [CNT_BITS-1:0] sat_update(input logic [CNT_BITS-1:0] cnt,
                                                       input logic taken);
        if (taken)
            return (&cnt) ? cnt : cnt + CNT_ONE;
        else
            return (cnt == '0) ? cnt : cnt - CNT_ONE;
    endfunction

    // New entries start one step either side of the taken threshold.
    function automatic logic [CNT_BITS-1:0] init_cnt(input logic taken);
        return taken ? {1'b1, {(CNT_BITS-1){1'b0}}} : {1'b0, {(CNT_BITS-1){1'b1}}};
    endfunction

    assign w_lu_idx    = vpc_i[INDEX_BITS:1];
    assign w_lu_tag    = vpc_i[63:INDEX_BITS+1];
    assign w_lu_entry  = r_btb[w_lu_idx];
    assign w_lu_hit    = w_lu_entry.valid && (w_lu_entry.tag == w_lu_tag);

    assign w_upd_idx   = branch_predict_i.pc[INDEX_BITS:1];
    assign w_upd_tag   = branch_predict_i.pc[63:INDEX_BITS+1];
    assign w_upd_entry = r_btb[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

    assign w_unused    = ^{vpc_i[0], branch_predict_i.pc[0], branch_predict_i.is_mispredict};

    always_comb begin
        branch_predict_o = '0;
        if (w_lu_hit) begin
            branch_predict_o.valid           = 1'b1;
            branch_predict_o.predict_address = w_lu_entry.target;
            branch_predict_o.is_lower_16     = w_lu_entry.is_lower_16;
            branch_predict_o.predict_taken   = w_lu_entry.cnt[CNT_BITS-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) r_btb[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) r_btb[i].valid <= 1'b0;
        end else if (branch_predict_i.valid) begin
            if (branch_predict_i.clear) begin
                r_btb[w_upd_idx].valid <= 1'b0;
            end else if (w_upd_hit) begin
                r_btb[w_upd_idx].target      <= branch_predict_i.target_address;
                r_btb[w_upd_idx].is_lower_16 <= branch_predict_i.is_lower_16;
                r_btb[w_upd_idx].cnt         <= sat_update(w_upd_entry.cnt, branch_predict_i.is_taken);
            end else begin
                r_btb[w_upd_idx].valid       <= 1'b1;
                r_btb[w_upd_idx].tag         <= w_upd_tag;
                r_btb[w_upd_idx].target      <= branch_predict_i.target_address;
                r_btb[w_upd_idx].is_lower_16 <= branch_predict_i.is_lower_16;
                r_btb[w_upd_idx].cnt         <= init_cnt(branch_predict_i.is_taken);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer against a behavioural model
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    typedef struct {
        branchpredict_sbe_t exp;
        string              name;
    } sb_t;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic               flush_i = 1'b0;
    logic [63:0]        vpc_i = '0;
    branchpredict_t     bp_i = '0;
    branchpredict_sbe_t bp_o;

    int total = 0;
    int bad   = 0;
    sb_t exp_q[$];

    // Reference model: 8 slots, slot = halfword address mod 8, tag = pc/16.
    bit          m_valid [8];
    logic [63:0] m_pc    [8];
    logic [63:0] m_tgt   [8];
    bit          m_l16   [8];
    int          m_cnt   [8];

    branch_target_buffer dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .vpc_i            (vpc_i),
        .branch_predict_i (bp_i),
        .branch_predict_o (bp_o)
    );

    always #5 clk = ~clk;

    function automatic int slot_of(input logic [63:0] pc);
        return int'((pc / 2) % 8);
    endfunction

    function automatic bit model_hit(input logic [63:0] pc);
        int s = slot_of(pc);
        return m_valid[s] && ((m_pc[s] / 16) == (pc / 16));
    endfunction

    function automatic branchpredict_sbe_t model_lookup(input logic [63:0] pc);
        branchpredict_sbe_t r = '0;
        int s = slot_of(pc);
        if (model_hit(pc)) begin
            r.valid           = 1'b1;
            r.predict_address = m_tgt[s];
            r.is_lower_16     = m_l16[s];
            r.predict_taken   = (m_cnt[s] >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_l16[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_update(input bit fl, input bit v, input bit clr, input bit tk,
                                input bit l16, input logic [63:0] pc, input logic [63:0] tgt);
        int s = slot_of(pc);
        if (fl) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
        end else if (v) begin
            if (clr) begin
                m_valid[s] = 0;
            end else if (model_hit(pc)) begin
                m_tgt[s] = tgt;
                m_l16[s] = l16;
                m_cnt[s] = tk ? ((m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1)
                              : ((m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1);
            end else begin
                m_valid[s] = 1;
                m_pc[s]    = pc;
                m_tgt[s]   = tgt;
                m_l16[s]   = l16;
                m_cnt[s]   = tk ? 2 : 1;
            end
        end
    endtask

    task automatic push_exp(input string name);
        sb_t e;
        e.exp  = model_lookup(vpc_i);
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name, input bit fl, input bit v, input bit clr, input bit tk,
                        input bit l16, input logic [63:0] pc, input logic [63:0] tgt,
                        input logic [63:0] vpc);
        @(posedge clk); #1;
        flush_i              = fl;
        vpc_i                = vpc;
        bp_i                 = '0;
        bp_i.pc              = pc;
        bp_i.target_address  = tgt;
        bp_i.is_mispredict   = 1'($urandom_range(0, 1));
        bp_i.is_taken        = tk;
        bp_i.is_lower_16     = l16;
        bp_i.valid           = v;
        bp_i.clear           = clr;
        push_exp(name);
        model_update(fl, v, clr, tk, l16, pc, tgt);
    endtask

    task automatic lookup(input string name, input logic [63:0] vpc);
        step(name, 0, 0, 0, 0, 0, 64'h0, 64'h0, vpc);
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bp_o !== e.exp) begin
                    bad++;
                    $display("FAIL %s: vpc=%h got=%h exp=%h", e.name, vpc_i, bp_o, e.exp);
                end
            end
        end
    end

    initial begin : driver
        logic [63:0] bases [4];
        logic [63:0] pc, vpc;
        int          budget;
        bases[0] = 64'h8000_0000; bases[1] = 64'h9000_0000;
        bases[2] = 64'h8000_0010; bases[3] = 64'hA000_1230;
        model_reset();

        vpc_i = 64'h8000_0000;
        @(posedge clk); #1;
        push_exp("in_reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;

        lookup("after_reset", 64'h8000_0000);
        step("alloc_taken", 0, 1, 0, 1, 0, 64'h8000_0010, 64'h8000_0100, 64'h8000_0000);
        lookup("hit_taken", 64'h8000_0010);
        for (int i = 0; i < 3; i++)
            step("nt_update", 0, 1, 0, 0, 0, 64'h8000_0010, 64'h8000_0100, 64'h8000_0010);
        lookup("cnt_floor", 64'h8000_0010);

        step("alias_alloc", 0, 1, 0, 1, 1, 64'h9000_0010, 64'h9000_0200, 64'h8000_0010);
        lookup("alias_evicted", 64'h8000_0010);
        lookup("alias_hit", 64'h9000_0010);

        step("same_idx_old", 0, 1, 0, 1, 0, 64'h8000_0020, 64'h8000_0300, 64'h8000_0020);
        lookup("same_idx_new", 64'h8000_0020);

        for (int i = 0; i < 4; i++)
            step("populate", 0, 1, 0, 1, 0, 64'h8000_0040 + 64'(2 * i), 64'h8000_1000 + 64'(i), 64'h0);
        lookup("pre_flush", 64'h8000_0042);
        step("flush_upd", 1, 1, 0, 1, 0, 64'h8000_0048, 64'h8000_2000, 64'h8000_0044);
        for (int i = 0; i < 5; i++)
            lookup("post_flush", 64'h8000_0040 + 64'(2 * i));

        step("clr_alloc", 0, 1, 0, 1, 0, 64'h8000_000A, 64'h8000_3000, 64'h0);
        lookup("clr_pre", 64'h8000_000A);
        step("clr_taken", 0, 1, 1, 1, 0, 64'h8000_000A, 64'h8000_4000, 64'h8000_000A);
        lookup("clr_post", 64'h8000_000A);

        step("pre_rst_alloc", 0, 1, 0, 1, 0, 64'h8000_000C, 64'h8000_5000, 64'h0);
        lookup("pre_rst_hit", 64'h8000_000C);
        @(posedge clk); #1;
        rst_ni        = 1'b0;
        vpc_i         = 64'h8000_000C;
        bp_i.valid    = 1'b1;
        bp_i.clear    = 1'b0;
        bp_i.pc       = 64'h8000_000E;
        model_reset();
        push_exp("mid_reset");
        @(posedge clk); #1;
        bp_i.valid = 1'b0;
        rst_ni     = 1'b1;
        lookup("post_rst_a", 64'h8000_000C);
        lookup("post_rst_b", 64'h8000_000E);

        for (int n = 0; n < 400; n++) begin
            pc  = bases[$urandom_range(0, 3)] + 64'(2 * $urandom_range(0, 7));
            vpc = bases[$urandom_range(0, 3)] + 64'(2 * $urandom_range(0, 7));
            step("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pc, {32'h0, $urandom}, vpc);
        end
        lookup("idle", 64'h0);

        budget = 100;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
